// File: rtl/decoder_pkg.sv
// Shared definitions for the 3-to-8 sequenced decoder.
//
// Provides the control-state enum (IDLE/SWEEP), the output FIFO depth, the code
// and decoded-word widths, and the one-hot decode helper used by the top level.
package decoder_pkg;

    localparam int unsigned FifoDepth = 2;
    localparam int unsigned CodeW     = 3;
    localparam int unsigned WordW     = 8;
    localparam int unsigned CountW    = $clog2(FifoDepth + 1);

    typedef logic [CodeW-1:0]  code_t;
    typedef logic [WordW-1:0]  word_t;
    typedef logic [CountW-1:0] count_t;

    localparam count_t FifoFull = CountW'(FifoDepth);
    localparam code_t  LastCode = CodeW'(WordW - 1);

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StSweep = 1'b1
    } state_e;

    // Active-high one-hot word; polarity is applied only at the output pin.
    function automatic word_t decode_onehot(code_t c);
        word_t w;
        w    = '0;
        w[c] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/decoder_fifo2.sv
// Two-entry, word-wide FIFO holding decoded words between the accept side and
// the consumer of the 3-to-8 decoder.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; empties the FIFO
//   push_i       write push_data_i (ignored when full)
//   push_data_i  word to enqueue
//   pop_i        drop the head entry (ignored when empty)
//   head_o       current head entry (meaningful only when not empty)
//   count_o      number of stored entries, 0..2
//   full_o       count_o == 2
//   empty_o      count_o == 0
module decoder_fifo2
    import decoder_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  word_t  push_data_i,
    input  logic   pop_i,
    output word_t  head_o,
    output count_t count_o,
    output logic   full_o,
    output logic   empty_o
);

    word_t  mem_q [FifoDepth];
    word_t  mem_d [FifoDepth];
    logic   wr_ptr_q, wr_ptr_d;
    logic   rd_ptr_q, rd_ptr_d;
    count_t count_q, count_d;

    logic push_ok;
    logic pop_ok;

    assign full_o  = (count_q == FifoFull);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // With two slots a 1-bit pointer wraps by simple inversion.
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + count_t'(1);
            2'b01:   count_d = count_q - count_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/decoder_3x8_seq.sv
// Registered 3-to-8 decoder with valid/ready handshakes on both sides and a
// 2-entry output FIFO. Accepted codes appear one cycle later as one-hot words
// (or one-cold when OUT_ACTIVE_LOW=1); y is all-inactive while out_valid=0.
//
// Optional automatic sweep (codes 0..7 in order) is built only when the macro
// DECODER_3X8_SEQ_SWEEP_EN is defined. Without it, sweep_start is ignored,
// sweep_busy is tied to 0 and the controller never leaves IDLE.
//
// Parameters:
//   OUT_ACTIVE_LOW  0: one-hot y, idle 8'h00; 1: one-cold y, idle 8'hFF
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       gates acceptance of new codes and keeps a sweep running
//   in_valid     code is present
//   in_ready     code accepted on this edge if in_valid is also high
//   code         binary index 0..7
//   out_valid    y holds a decoded word
//   out_ready    consumer takes y on this edge
//   y            decoded word
//   sweep_start  request an automatic 0..7 sweep
//   sweep_busy   sweep in progress
module decoder_3x8_seq
    import decoder_pkg::*;
#(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CodeW-1:0] code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WordW-1:0] y,
    input  logic             sweep_start,
    output logic             sweep_busy
);

    state_e state_q, state_d;

    logic   fifo_push;
    logic   fifo_pop;
    code_t  push_code;
    word_t  fifo_head;
    count_t fifo_count;
    logic   fifo_full;
    logic   fifo_empty;
    word_t  out_word;

`ifdef DECODER_3X8_SEQ_SWEEP_EN
    code_t sweep_idx_q, sweep_idx_d;
`else
    logic unused_sweep_start;
    logic unused_fifo_full;
    assign unused_sweep_start = sweep_start;
    assign unused_fifo_full   = fifo_full;
`endif

    // rst_n is included so in_ready reads 0 while reset is held.
    assign in_ready = rst_n && enable && (fifo_count < FifoFull) && (state_q == StIdle);

    always_comb begin
        state_d   = state_q;
        fifo_push = 1'b0;
        push_code = code;
`ifdef DECODER_3X8_SEQ_SWEEP_EN
        sweep_idx_d = sweep_idx_q;
`endif

        // in_ready is low in SWEEP, so this never collides with a sweep push.
        if (in_valid && in_ready) begin
            fifo_push = 1'b1;
            push_code = code;
        end

`ifdef DECODER_3X8_SEQ_SWEEP_EN
        unique case (state_q)
            StIdle: begin
                if (sweep_start && enable && (fifo_count == '0)) begin
                    state_d     = StSweep;
                    sweep_idx_d = '0;
                end
            end
            StSweep: begin
                if (!enable) begin
                    state_d     = StIdle;
                    sweep_idx_d = '0;
                end else if (!fifo_full) begin
                    fifo_push = 1'b1;
                    push_code = sweep_idx_q;
                    if (sweep_idx_q == LastCode) begin
                        state_d     = StIdle;
                        sweep_idx_d = '0;
                    end else begin
                        sweep_idx_d = sweep_idx_q + code_t'(1);
                    end
                end
                // While full the index holds, so no code is skipped.
            end
        endcase
`else
        state_d = StIdle;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef DECODER_3X8_SEQ_SWEEP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_idx_q <= '0;
        end else begin
            sweep_idx_q <= sweep_idx_d;
        end
    end

    assign sweep_busy = (state_q == StSweep);
`else
    assign sweep_busy = 1'b0;
`endif

    decoder_fifo2 u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (decode_onehot(push_code)),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;

    // Mask to all-zero when empty, then apply output polarity.
    assign out_word = out_valid ? fifo_head : '0;
    assign y        = OUT_ACTIVE_LOW ? ~out_word : out_word;

endmodule

// File: doc/decoder_3x8_seq.md
DECODER_3X8_SEQ -- requirements
Module: decoder_3x8_seq

Interface
REQ-001 SHALL have parameter OUT_ACTIVE_LOW, default 0, meaning 0 gives one-hot y and 1 gives one-cold y.
REQ-002 SHALL have port clk, input, 1, the single clock; all flops rising-edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port enable, input, 1, global accept enable.
REQ-005 SHALL have port in_valid, input, 1, code present.
REQ-006 SHALL have port in_ready, output, 1, block accepts code this cycle.
REQ-007 SHALL have port code, input, 3, binary index 0..7.
REQ-008 SHALL have port out_valid, output, 1, y holds a decoded word.
REQ-009 SHALL have port out_ready, input, 1, consumer takes y this cycle.
REQ-010 SHALL have port y, output, 8, decoded word.
REQ-011 SHALL have port sweep_start, input, 1, request an automatic 0..7 sweep.
REQ-012 SHALL have port sweep_busy, output, 1, sweep in progress.

Function
REQ-013 SHALL accept a code on a rising edge where in_valid and in_ready are both 1.
REQ-014 SHALL push the accepted code's decoded word (bit[code] active, all other bits inactive) into a 2-entry output FIFO on that same edge.
REQ-015 SHALL assert out_valid on the cycle after the push, giving 1-cycle latency; there is no combinational input-to-output path.
REQ-016 SHALL drive in_ready = enable AND (FIFO count < 2) AND state==IDLE.
REQ-017 SHALL present the FIFO head on y while out_valid=1, and SHALL pop it on an edge where out_valid and out_ready are both 1.
REQ-018 SHALL drive y to all-inactive while out_valid=0: 8'h00, or 8'hFF when OUT_ACTIVE_LOW=1.
REQ-019 SHALL keep count unchanged on a simultaneous push and pop at count 1, and SHALL preserve order.
REQ-020 SHALL hold in_ready=0 at count 2 (no full bypass), even when out_ready=1 in that cycle.
REQ-021 SHALL hold y stable while out_valid=1 and out_ready=0.
REQ-022 SHALL keep draining already-queued entries when enable=0; enable gates only acceptance.
REQ-023 SHALL use states IDLE and SWEEP; IDLE->SWEEP when sweep_start=1, enable=1 and count==0.
REQ-024 SHALL, in SWEEP, push codes 0,1,...,7 in order, one per cycle when count<2; it SHALL stall without skipping while full.
REQ-025 SHALL go SWEEP->IDLE on the edge that pushes code 7.
REQ-026 SHALL abort SWEEP->IDLE when enable=0, stopping pushes; queued entries still drain.
REQ-027 SHALL drive sweep_busy=1 exactly while state==SWEEP.
REQ-028 SHALL ignore sweep_start while in SWEEP, or while in IDLE with count!=0.

Reset
REQ-029 SHALL, when rst_n=0, asynchronously clear the FIFO (count 0), state to IDLE, sweep index 0, out_valid=0, in_ready=0, sweep_busy=0, and y inactive.
REQ-030 SHALL discard queued entries and any in-progress sweep on reset mid-operation; no partial output follows deassertion.
REQ-031 SHALL, on the first edge after rst_n deasserts, evaluate in_ready per REQ-016.

Configuration
REQ-032 SHALL implement the sweep feature (REQ-023..REQ-028) only when macro DECODER_3X8_SEQ_SWEEP_EN is defined.
REQ-033 SHALL, without DECODER_3X8_SEQ_SWEEP_EN, keep the sweep_start port but ignore it, tie sweep_busy to 0, and stay permanently in IDLE.

Structure
REQ-034 SHALL take the state enum (IDLE, SWEEP), FIFO depth constant 2, code width 3, and word width 8 from shared package decoder_pkg.
REQ-035 SHALL implement the FIFO as sub-module decoder_fifo2: 2 entries x 8 bits, push/pop/count/full/empty.

Verification
REQ-036 SHALL cover single decode: code=3'd5, in_valid pulse, out_ready=1 -> next cycle out_valid=1, y=8'h20, popped; with OUT_ACTIVE_LOW=1, y=8'hDF.
REQ-037 SHALL cover backpressure: out_ready=0, send codes 1,2,4 -> codes 1 and 2 accepted, in_ready=0 for code 4; release out_ready -> y sequence 8'h02, 8'h04, 8'h10.
REQ-038 SHALL cover enable gating: enable=0 with in_valid=1, code=3'd7 -> in_ready=0, no push, y=8'h00; a queued entry still drains.
REQ-039 SHALL cover a full sweep (macro on): sweep_start at count 0, out_ready=1 -> y sequence 8'h01..8'h80 in order, sweep_busy high 8 cycles, then IDLE.
REQ-040 SHALL cover sweep abort and reset: enable=0 after code 3 is pushed -> sweep_busy drops, no code 4; a repeat run with rst_n pulsed mid-sweep -> all outputs at reset values, FIFO empty.
REQ-041 SHALL cover the macro-off build: sweep_start=1 -> sweep_busy stays 0 and there is no output activity.
